// File: rtl/noc_local_traffic_gen.sv
// LFSR-driven packet source for a mesh router LOCAL input, with a ready/valid handshake.
// Optional feature macro: TGEN_SELF_DEST_EN (allow destination == own coordinates).
module noc_local_traffic_gen #(
   parameter int          MESH_SIDE   = 4,
   parameter int          DATA_WIDTH  = 32,
   parameter int          SRC_X       = 0,
   parameter int          SRC_Y       = 0,
   parameter int          INJ_PERCENT = 10,
   parameter logic [15:0] SEED        = 16'hACE1,
   parameter int          PKT_LIMIT   = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   output logic                          s_delta_x,
   output logic                          s_delta_y,
   output logic [$clog2(MESH_SIDE)-1:0]  dest_x,
   output logic [$clog2(MESH_SIDE)-1:0]  dest_y,
   output logic [DATA_WIDTH-1:0]         data,
   output logic                          valid,
   input  logic                          ready,
   output logic [31:0]                   sent_count,
   output logic [31:0]                   stall_count,
   output logic                          done
);

   localparam int          CW        = $clog2(MESH_SIDE);
   localparam int          SW        = DATA_WIDTH - 8;
   localparam logic [7:0]  THRESH    = 8'((INJ_PERCENT * 128) / 100);
   localparam logic [15:0] LFSR_INIT = (SEED == 16'h0) ? 16'hACE1 : SEED;
   localparam logic [CW:0] SIDE_C    = (CW+1)'(MESH_SIDE);
   localparam logic [CW-1:0] SRC_XC  = CW'(SRC_X);
   localparam logic [CW-1:0] SRC_YC  = CW'(SRC_Y);
   localparam logic [CW-1:0] ALT_X   = CW'((SRC_X + 1) % MESH_SIDE);
   localparam logic [3:0]  SRC_X4    = 4'(SRC_X);
   localparam logic [3:0]  SRC_Y4    = 4'(SRC_Y);
   localparam logic [31:0] LIMIT     = 32'(PKT_LIMIT);

   typedef enum logic [1:0] {S_IDLE, S_OFFER, S_DONE} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [15:0]           r_lfsr;
   logic [SW-1:0]         r_stamp;
   logic [CW-1:0]         r_dest_x;
   logic [CW-1:0]         r_dest_y;
   logic                  r_dlt_x;
   logic                  r_dlt_y;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic                  r_done;
   logic [31:0]           r_sent;
   logic [31:0]           r_stall;

   logic [15:0]   w_lfsr_next;
   logic          w_xfer;
   logic          w_last;
   logic          w_decide;
   logic          w_inject;
   logic [CW-1:0] w_rx;
   logic [CW-1:0] w_ry;
   logic [CW-1:0] w_dx_red;
   logic [CW-1:0] w_dy_red;
   logic [CW-1:0] w_dx_fin;

   // Galois form of x^16+x^14+x^13+x^11+1, shifting right
   assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);

   assign w_xfer   = (r_state == S_OFFER) && ready;
   assign w_last   = (LIMIT != 32'd0) && w_xfer && (r_sent == LIMIT - 32'd1);
   assign w_decide = en && !w_last && ((r_state == S_IDLE) || w_xfer);
   assign w_inject = w_decide && ({1'b0, r_lfsr[6:0]} < THRESH);

   // Raw field spans less than 2*MESH_SIDE, so one conditional subtract reduces it
   assign w_rx     = r_lfsr[8 +: CW];
   assign w_ry     = r_lfsr[12 +: CW];
   assign w_dx_red = ({1'b0, w_rx} >= SIDE_C) ? (w_rx - SIDE_C[CW-1:0]) : w_rx;
   assign w_dy_red = ({1'b0, w_ry} >= SIDE_C) ? (w_ry - SIDE_C[CW-1:0]) : w_ry;

`ifdef TGEN_SELF_DEST_EN
   assign w_dx_fin = w_dx_red;
`else
   assign w_dx_fin = ((w_dx_red == SRC_XC) && (w_dy_red == SRC_YC)) ? ALT_X : w_dx_red;
`endif

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_inject) w_state_next = S_OFFER;
         end
         S_OFFER: begin
            if (w_last)      w_state_next = S_DONE;
            else if (w_xfer) w_state_next = w_inject ? S_OFFER : S_IDLE;
         end
         S_DONE:  w_state_next = S_DONE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_lfsr   <= LFSR_INIT;
         r_stamp  <= '0;
         r_dest_x <= '0;
         r_dest_y <= '0;
         r_dlt_x  <= 1'b0;
         r_dlt_y  <= 1'b0;
         r_data   <= '0;
         r_valid  <= 1'b0;
         r_done   <= 1'b0;
         r_sent   <= '0;
         r_stall  <= '0;
      end else begin
         r_state <= w_state_next;
         r_lfsr  <= w_lfsr_next;
         r_stamp <= r_stamp + SW'(1);
         r_valid <= (w_state_next == S_OFFER);
         r_done  <= (w_state_next == S_DONE);
         if (w_inject) begin
            r_dest_x <= w_dx_fin;
            r_dest_y <= w_dy_red;
            r_dlt_x  <= (w_dx_fin < SRC_XC);
            r_dlt_y  <= (w_dy_red < SRC_YC);
            r_data   <= {SRC_X4, SRC_Y4, r_stamp};
         end
         if (w_xfer && (r_sent != '1)) r_sent <= r_sent + 32'd1;
         if ((r_state == S_OFFER) && !ready && (r_stall != '1)) r_stall <= r_stall + 32'd1;
      end
   end

   assign s_delta_x   = r_dlt_x;
   assign s_delta_y   = r_dlt_y;
   assign dest_x      = r_dest_x;
   assign dest_y      = r_dest_y;
   assign data        = r_data;
   assign valid       = r_valid;
   assign sent_count  = r_sent;
   assign stall_count = r_stall;
   assign done        = r_done;

endmodule
